// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory bus bundle for mem_port_arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_grant;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_rw;
  logic        d_byte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_grant;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        busy;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_dm_byte;
  logic [31:0] mem_data_out;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_grant, i_valid, i_rdata,
    input  d_req, d_rw, d_byte, d_addr, d_wdata,
    output d_grant, d_valid, d_rdata, d_done,
    output busy,
    output mem_address, mem_data_in, mem_access_size,
    output mem_rw, mem_enable, mem_dm_byte,
    input  mem_data_out
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_grant, i_valid, i_rdata,
    output d_req, d_rw, d_byte, d_addr, d_wdata,
    input  d_grant, d_valid, d_rdata, d_done,
    input  busy,
    input  mem_address, mem_data_in, mem_access_size,
    input  mem_rw, mem_enable, mem_dm_byte,
    output mem_data_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory between fetch (I) and data (D) ports.
// Ports: clock, reset (sync, active-high), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             owner_i;
  logic             owner_d;
  logic             cancelled;
  logic             i_wins;
  logic             cancel_now;

  // D has priority unless fetch has been starved long enough.
  always_comb begin
    i_wins     = bus.i_req && (!bus.d_req || starve_cnt == LIM);
    cancel_now = cancelled || bus.i_flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= S_IDLE;
      starve_cnt          <= '0;
      owner_i             <= 1'b0;
      owner_d             <= 1'b0;
      cancelled           <= 1'b0;
      bus.i_grant         <= 1'b0;
      bus.i_valid         <= 1'b0;
      bus.i_rdata         <= '0;
      bus.d_grant         <= 1'b0;
      bus.d_valid         <= 1'b0;
      bus.d_rdata         <= '0;
      bus.d_done          <= 1'b0;
      bus.busy            <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_data_in     <= '0;
      bus.mem_access_size <= '0;
      bus.mem_rw          <= 1'b0;
      bus.mem_enable      <= 1'b0;
      bus.mem_dm_byte     <= 1'b0;
    end else begin
      bus.i_grant         <= 1'b0;
      bus.d_grant         <= 1'b0;
      bus.i_valid         <= 1'b0;
      bus.d_valid         <= 1'b0;
      bus.d_done          <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_data_in     <= '0;
      bus.mem_access_size <= '0;
      bus.mem_rw          <= 1'b0;
      bus.mem_enable      <= 1'b0;
      bus.mem_dm_byte     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cancelled <= 1'b0;
          owner_i   <= 1'b0;
          owner_d   <= 1'b0;
          if (bus.i_req || bus.d_req) begin
            state          <= S_ISSUE;
            bus.busy       <= 1'b1;
            bus.mem_enable <= 1'b1;
            if (i_wins) begin
              owner_i         <= 1'b1;
              bus.i_grant     <= 1'b1;
              bus.mem_address <= bus.i_addr;
              bus.mem_rw      <= 1'b1;
              starve_cnt      <= '0;
            end else begin
              owner_d         <= 1'b1;
              bus.d_grant     <= 1'b1;
              bus.mem_address <= bus.d_addr;
              bus.mem_rw      <= bus.d_rw;
              bus.mem_data_in <= bus.d_wdata;
              bus.mem_dm_byte <= bus.d_byte && !bus.d_rw;
              if (!bus.i_req)
                starve_cnt <= '0;
              else if (starve_cnt != LIM)
                starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (owner_i && bus.i_flush)
            cancelled <= 1'b1;
          // mem_rw still holds the issued command here.
          if (!bus.mem_rw) begin
            state      <= S_IDLE;
            bus.busy   <= 1'b0;
            bus.d_done <= owner_d;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          if (owner_i) begin
            if (!cancel_now) begin
              bus.i_rdata <= bus.mem_data_out;
              bus.i_valid <= 1'b1;
            end
          end else if (owner_d) begin
            bus.d_rdata <= bus.mem_data_out;
            bus.d_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Includes a big-endian word memory with one-cycle read latency.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_W(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:255];

  always @(posedge clock) begin
    if (bus.mem_enable) begin
      if (bus.mem_rw) begin
        bus.mem_data_out <= mem[bus.mem_address[9:2]];
      end else if (bus.mem_dm_byte) begin
        mem[bus.mem_address[9:2]][8*(3-int'(bus.mem_address[1:0])) +: 8]
          <= bus.mem_data_in[7:0];
      end else begin
        mem[bus.mem_address[9:2]] <= bus.mem_data_in;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    checks++;
    if ({bus.i_grant, bus.i_valid, bus.d_grant, bus.d_valid, bus.d_done,
         bus.busy, bus.mem_enable, bus.mem_rw, bus.mem_dm_byte} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got nonzero expected 0");
    end
    checks++;
    if ({bus.i_rdata, bus.d_rdata, bus.mem_address, bus.mem_data_in,
         bus.mem_access_size} !== 130'b0) begin
      errors++;
      $display("FAIL reset_data: got nonzero expected 0");
    end
  endtask

  task automatic test_fetch;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8002_0000;
    tick;
    checks++;
    if ({bus.i_grant, bus.mem_enable, bus.mem_rw} !== 3'b111) begin
      errors++;
      $display("FAIL fetch_issue: got %b expected 111",
               {bus.i_grant, bus.mem_enable, bus.mem_rw});
    end
    chk("fetch_addr", bus.mem_address, 32'h8002_0000);
    bus.i_req = 1'b0;
    tick;
    checks++;
    if ({bus.i_valid, bus.mem_enable, bus.busy} !== 3'b001) begin
      errors++;
      $display("FAIL fetch_wait: got %b expected 001",
               {bus.i_valid, bus.mem_enable, bus.busy});
    end
    tick;
    chk("fetch_valid", {31'b0, bus.i_valid}, 32'd1);
    chk("fetch_rdata", bus.i_rdata, 32'h3C01_1234);
    tick;
    chk("fetch_valid_drop", {31'b0, bus.i_valid}, 32'd0);
  endtask

  task automatic test_store_load;
    bus.d_req   = 1'b1;
    bus.d_rw    = 1'b0;
    bus.d_byte  = 1'b0;
    bus.d_addr  = 32'h8002_0010;
    bus.d_wdata = 32'hDEAD_BEEF;
    tick;
    chk("store_grant", {31'b0, bus.d_grant}, 32'd1);
    chk("store_wdata", bus.mem_data_in, 32'hDEAD_BEEF);
    chk("store_rw", {31'b0, bus.mem_rw}, 32'd0);
    bus.d_req = 1'b0;
    tick;
    chk("store_done", {31'b0, bus.d_done}, 32'd1);
    bus.d_req = 1'b1;
    bus.d_rw  = 1'b1;
    tick;
    chk("load_grant", {31'b0, bus.d_grant}, 32'd1);
    chk("load_done_drop", {31'b0, bus.d_done}, 32'd0);
    bus.d_req = 1'b0;
    tick;
    tick;
    chk("load_valid", {31'b0, bus.d_valid}, 32'd1);
    chk("load_rdata", bus.d_rdata, 32'hDEAD_BEEF);
  endtask

  task automatic test_starvation;
    bit exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit got [10];
    int n;
    n = 0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h8002_0000;
    bus.d_req   = 1'b1;
    bus.d_rw    = 1'b0;
    bus.d_byte  = 1'b0;
    bus.d_addr  = 32'h8002_0030;
    bus.d_wdata = 32'h1234_5678;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      tick;
      if (bus.i_grant && bus.d_grant) begin
        checks++;
        errors++;
        $display("FAIL dual_grant: got 11 expected one-hot");
      end
      if (bus.d_grant) begin
        got[n] = 1'b0;
        n++;
      end else if (bus.i_grant) begin
        got[n] = 1'b1;
        n++;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk("starve_count", n, 10);
    for (int k = 0; k < 10; k++) begin
      if (k < n) begin
        checks++;
        if (got[k] !== exp_seq[k]) begin
          errors++;
          $display("FAIL starve_order[%0d]: got %0d expected %0d",
                   k, got[k], exp_seq[k]);
        end
      end
    end
    repeat (4) tick;
  endtask

  task automatic test_flush;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8002_0004;
    tick;
    chk("flush_grant", {31'b0, bus.i_grant}, 32'd1);
    bus.i_req = 1'b0;
    tick;
    bus.i_flush = 1'b1;
    tick;
    bus.i_flush = 1'b0;
    chk("flush_no_valid", {31'b0, bus.i_valid}, 32'd0);
    chk("flush_rdata_kept", bus.i_rdata, 32'h3C01_1234);
    chk("flush_idle", {31'b0, bus.busy}, 32'd0);
    tick;
    chk("flush_no_late_valid", {31'b0, bus.i_valid}, 32'd0);
  endtask

  task automatic test_byte_store;
    bus.d_req   = 1'b1;
    bus.d_rw    = 1'b0;
    bus.d_byte  = 1'b1;
    bus.d_addr  = 32'h8002_0021;
    bus.d_wdata = 32'h0000_00AB;
    tick;
    chk("byte_dm", {31'b0, bus.mem_dm_byte}, 32'd1);
    bus.d_req  = 1'b0;
    bus.d_byte = 1'b0;
    tick;
    chk("byte_done", {31'b0, bus.d_done}, 32'd1);
    bus.d_req  = 1'b1;
    bus.d_rw   = 1'b1;
    bus.d_addr = 32'h8002_0020;
    tick;
    chk("byte_load_dm", {31'b0, bus.mem_dm_byte}, 32'd0);
    bus.d_req = 1'b0;
    tick;
    tick;
    chk("byte_load_valid", {31'b0, bus.d_valid}, 32'd1);
    chk("byte_lane", bus.d_rdata, 32'h00AB_0000);
    tick;
  endtask

  task automatic test_reset_mid;
    bus.d_req  = 1'b1;
    bus.d_rw   = 1'b1;
    bus.d_addr = 32'h8002_0010;
    tick;
    chk("rst_mid_grant", {31'b0, bus.d_grant}, 32'd1);
    bus.d_req = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_mid_no_valid", {31'b0, bus.d_valid}, 32'd0);
    chk("rst_mid_rdata", bus.d_rdata, 32'h0);
    chk("rst_mid_ctl", {28'b0, bus.busy, bus.mem_enable, bus.d_grant,
        bus.i_grant}, 32'h0);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8002_0000;
    tick;
    chk("rst_mid_igrant", {31'b0, bus.i_grant}, 32'd1);
    bus.i_req = 1'b0;
    tick;
    tick;
    chk("rst_mid_ivalid", {31'b0, bus.i_valid}, 32'd1);
    chk("rst_mid_irdata", bus.i_rdata, 32'h3C01_1234);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_flush = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_rw    = 1'b0;
    bus.d_byte  = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[0] = 32'h3C01_1234;
    mem[1] = 32'h1111_2222;
    test_reset;
    test_fetch;
    test_store_load;
    test_starvation;
    test_flush;
    test_byte_store;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
